// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
//   Shared definitions for the sequential shift-and-add multiplier:
//   FSM state encoding, default operand width and the counter-width helper.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned WIDTH_DEFAULT = 4;

    // Bits needed to hold the bit counter, which counts WIDTH-1 down to 0.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if
//   Operand/result handshake bundle for seq_mult.
//   master : drives in_valid, a, b, signed_mode, out_ready
//   slave  : drives in_ready, out_valid, product, busy
interface seq_mult_if
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/twos_negate.sv
// twos_negate
//   Conditional two's-complement negate: o_out = i_en ? -i_in : i_in.
//   i_en  : negate enable
//   i_in  : N-bit operand
//   o_out : N-bit result
module twos_negate
    import seq_mult_pkg::*;
#(
    parameter int unsigned N = WIDTH_DEFAULT
) (
    input  logic         i_en,
    input  logic [N-1:0] i_in,
    output logic [N-1:0] o_out
);
    assign o_out = i_en ? (~i_in + N'(1)) : i_in;
endmodule

// File: rtl/seq_mult.sv
// seq_mult
//   Sequential shift-and-add multiplier, one multiplier bit per cycle,
//   full 2*WIDTH-bit product, optional two's-complement mode.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_mult_if slave (operand in_valid/in_ready handshake,
//           product out_valid/out_ready handshake, busy status)
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_mult_if.slave   bus
);
    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_mcand;    // |a|
    logic [WIDTH-1:0] r_acc_hi;   // upper accumulator half
    logic [WIDTH-1:0] r_acc_lo;   // multiplier shifting out, product low bits shifting in
    logic             r_neg;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_product;

    logic             w_accept;
    logic             w_zero;
    logic             w_last;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_sum;
    logic [PW-1:0]    w_acc_next;
    logic [PW-1:0]    w_prod_fixed;

    assign w_accept = bus.in_valid && (r_state == S_IDLE);
    // Raw-value test: a signed operand is zero exactly when its magnitude is.
    assign w_zero   = (bus.a == '0) || (bus.b == '0);
    assign w_last   = (r_cnt == '0);

    twos_negate #(.N(WIDTH)) u_abs_a (
        .i_en  (bus.signed_mode && bus.a[WIDTH-1]),
        .i_in  (bus.a),
        .o_out (w_abs_a)
    );

    twos_negate #(.N(WIDTH)) u_abs_b (
        .i_en  (bus.signed_mode && bus.b[WIDTH-1]),
        .i_in  (bus.b),
        .o_out (w_abs_b)
    );

    // Conditional add of |a| into the upper half with a carry bit, then the
    // whole {carry, acc_hi, acc_lo} shifts right by one.
    assign w_sum      = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mcand} : '0);
    assign w_acc_next = {w_sum, r_acc_lo[WIDTH-1:1]};

    twos_negate #(.N(PW)) u_sign_fix (
        .i_en  (r_neg),
        .i_in  (w_acc_next),
        .o_out (w_prod_fixed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept)       w_next_state = w_zero ? S_DONE : S_RUN;
            S_RUN:  if (w_last)         w_next_state = S_DONE;
            S_DONE: if (bus.out_ready)  w_next_state = S_IDLE;
            default:                    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= w_abs_a;
                        r_acc_lo <= w_abs_b;
                        r_acc_hi <= '0;
                        r_neg    <= bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_cnt    <= CW'(WIDTH - 1);
                        if (w_zero) begin
                            r_product <= '0;
                        end
                    end
                end
                S_RUN: begin
                    {r_acc_hi, r_acc_lo} <= w_acc_next;
                    r_cnt                <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_product <= w_prod_fixed;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.product   = r_product;

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult
//   Self-checking bench for seq_mult at WIDTH 4, 8 and 16 against an
//   integer-arithmetic reference product.
module tb_seq_mult;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seq_mult_if #(.WIDTH(4))  b4  ();
    seq_mult_if #(.WIDTH(8))  b8  ();
    seq_mult_if #(.WIDTH(16)) b16 ();

    seq_mult #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    seq_mult #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    seq_mult #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_in(input int unsigned w, input logic v, input logic [15:0] a,
                            input logic [15:0] b, input logic sm);
        case (w)
            4: begin
                b4.in_valid = v; b4.a = a[3:0]; b4.b = b[3:0]; b4.signed_mode = sm;
            end
            8: begin
                b8.in_valid = v; b8.a = a[7:0]; b8.b = b[7:0]; b8.signed_mode = sm;
            end
            default: begin
                b16.in_valid = v; b16.a = a; b16.b = b; b16.signed_mode = sm;
            end
        endcase
    endtask

    task automatic set_ordy(input int unsigned w, input logic r);
        case (w)
            4:       b4.out_ready  = r;
            8:       b8.out_ready  = r;
            default: b16.out_ready = r;
        endcase
    endtask

    function automatic logic [31:0] get_prod(input int unsigned w);
        case (w)
            4:       return 32'(b4.product);
            8:       return 32'(b8.product);
            default: return b16.product;
        endcase
    endfunction

    function automatic logic [31:0] get_valid(input int unsigned w);
        case (w)
            4:       return 32'(b4.out_valid);
            8:       return 32'(b8.out_valid);
            default: return 32'(b16.out_valid);
        endcase
    endfunction

    function automatic logic [31:0] get_ready(input int unsigned w);
        case (w)
            4:       return 32'(b4.in_ready);
            8:       return 32'(b8.in_ready);
            default: return 32'(b16.in_ready);
        endcase
    endfunction

    function automatic logic [31:0] get_busy(input int unsigned w);
        case (w)
            4:       return 32'(b4.busy);
            8:       return 32'(b8.busy);
            default: return 32'(b16.busy);
        endcase
    endfunction

    // Reference: interpret operands as plain integers (signed when sm=1),
    // multiply, and keep the low 2*w bits.
    function automatic logic [31:0] ref_mul(input int unsigned w, input logic [15:0] a,
                                            input logic [15:0] b, input logic sm);
        longint av, bv, p;
        av = longint'(a) & ((longint'(1) << w) - 1);
        bv = longint'(b) & ((longint'(1) << w) - 1);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        p = av * bv;
        return 32'(p & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // One full transaction: accept, wait for the result, optional stall, drain.
    task automatic xact(input int unsigned w, input logic [15:0] a_in, input logic [15:0] b_in,
                        input logic sm, input int unsigned stall);
        logic [15:0] msk, a, b;
        logic [31:0] exp_p;
        int unsigned lat, exp_lat, guard;
        msk     = 16'((32'd1 << w) - 1);
        a       = a_in & msk;
        b       = b_in & msk;
        exp_p   = ref_mul(w, a, b, sm);
        exp_lat = (a == 16'd0 || b == 16'd0) ? 1 : w + 1;
        guard = 0;
        while (get_ready(w) != 32'd1 && guard < 50) begin
            tick();
            guard++;
        end
        check("ready_before", get_ready(w), 32'd1);
        drive_in(w, 1'b1, a, b, sm);
        tick();
        // Scramble operands after acceptance; the result must not move.
        drive_in(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        lat = 1;
        while (get_valid(w) != 32'd1 && lat < 4 * w + 8) begin
            tick();
            lat++;
        end
        check("latency", lat, exp_lat);
        check("product", get_prod(w), exp_p);
        if (stall > 0) begin
            repeat (stall) tick();
            check("hold_valid", get_valid(w), 32'd1);
            check("hold_prod", get_prod(w), exp_p);
        end
        set_ordy(w, 1'b1);
        tick();
        set_ordy(w, 1'b0);
        check("valid_drop", get_valid(w), 32'd0);
        check("ready_after", get_ready(w), 32'd1);
    endtask

    initial begin
        int unsigned g;
        rst_n = 1'b0;
        drive_in(4, 1'b0, 16'd0, 16'd0, 1'b0);
        drive_in(8, 1'b0, 16'd0, 16'd0, 1'b0);
        drive_in(16, 1'b0, 16'd0, 16'd0, 1'b0);
        set_ordy(4, 1'b0);
        set_ordy(8, 1'b0);
        set_ordy(16, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", get_valid(4), 32'd0);
        check("rst_prod", get_prod(4), 32'd0);
        check("rst_busy", get_busy(4), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_ready", get_ready(4), 32'd1);
        check("rel_busy", get_busy(4), 32'd0);
        check("rel_prod16", get_prod(16), 32'd0);

        // Directed cases at WIDTH=4
        xact(4, 16'd15, 16'd15, 1'b0, 0);
        check("u15x15", get_prod(4), 32'hE1);
        xact(4, 16'h8, 16'h8, 1'b1, 0);
        check("s-8x-8", get_prod(4), 32'h40);
        xact(4, 16'h8, 16'h7, 1'b1, 1);
        check("s-8x7", get_prod(4), 32'hC8);
        xact(4, 16'h3, 16'hF, 1'b1, 0);
        check("s3x-1", get_prod(4), 32'hFD);
        xact(4, 16'd0, 16'd13, 1'b0, 0);
        xact(4, 16'd0, 16'd13, 1'b1, 0);
        xact(4, 16'd9, 16'd0, 1'b0, 0);
        xact(4, 16'd9, 16'd0, 1'b1, 0);

        // Backpressure: result held, second request ignored until drained
        drive_in(4, 1'b1, 16'd5, 16'd3, 1'b0);
        tick();
        drive_in(4, 1'b0, 16'd0, 16'd0, 1'b0);
        g = 0;
        while (get_valid(4) != 32'd1 && g < 20) begin
            tick();
            g++;
        end
        check("bp_valid", get_valid(4), 32'd1);
        drive_in(4, 1'b1, 16'd2, 16'd2, 1'b0);
        repeat (10) begin
            tick();
            check("bp_prod", get_prod(4), 32'd15);
            check("bp_in_ready", get_ready(4), 32'd0);
            check("bp_valid_held", get_valid(4), 32'd1);
        end
        set_ordy(4, 1'b1);
        tick();
        set_ordy(4, 1'b0);
        check("bp_rel_valid", get_valid(4), 32'd0);
        check("bp_rel_ready", get_ready(4), 32'd1);
        check("bp_rel_prod", get_prod(4), 32'd15);
        tick();
        drive_in(4, 1'b0, 16'd0, 16'd0, 1'b0);
        check("bp_next_busy", get_busy(4), 32'd1);
        check("bp_next_ready", get_ready(4), 32'd0);
        g = 0;
        while (get_valid(4) != 32'd1 && g < 20) begin
            tick();
            g++;
        end
        check("bp_next_prod", get_prod(4), 32'd4);
        set_ordy(4, 1'b1);
        tick();
        set_ordy(4, 1'b0);

        // Reset two cycles into RUN
        drive_in(4, 1'b1, 16'd11, 16'd13, 1'b0);
        tick();
        drive_in(4, 1'b0, 16'd0, 16'd0, 1'b0);
        tick();
        tick();
        check("mid_busy_pre", get_busy(4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", get_valid(4), 32'd0);
        check("mid_rst_prod", get_prod(4), 32'd0);
        check("mid_rst_busy", get_busy(4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_rel_ready", get_ready(4), 32'd1);
        check("mid_rel_prod", get_prod(4), 32'd0);
        xact(4, 16'd6, 16'd7, 1'b0, 0);
        check("six_by_seven", get_prod(4), 32'h2A);

        // Exhaustive WIDTH=4, both modes, random output stalls
        for (int unsigned sm = 0; sm < 2; sm++) begin
            for (int unsigned av = 0; av < 16; av++) begin
                for (int unsigned bv = 0; bv < 16; bv++) begin
                    xact(4, 16'(av), 16'(bv), 1'(sm), $urandom_range(0, 2));
                end
            end
        end

        // WIDTH=8 and WIDTH=16: corners then random
        xact(8, 16'hFF, 16'hFF, 1'b0, 0);
        xact(8, 16'h80, 16'h80, 1'b1, 0);
        xact(8, 16'h80, 16'h7F, 1'b1, 1);
        xact(16, 16'hFFFF, 16'hFFFF, 1'b0, 0);
        xact(16, 16'h8000, 16'h8000, 1'b1, 0);
        xact(16, 16'h8000, 16'h7FFF, 1'b1, 2);
        xact(16, 16'h0000, 16'h8000, 1'b1, 0);
        for (int unsigned i = 0; i < 150; i++) begin
            xact(8, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3));
        end
        for (int unsigned i = 0; i < 150; i++) begin
            xact(16, 16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
